// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter: round-robin sharing of one 32-bit adder among NUM_REQ
// requesters. The optional overflow flag is enabled by ADDER_ARB_OVF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);
  assign out = a + b;
endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_sum,
  output logic [ID_W-1:0]        resp_id,
`ifdef ADDER_ARB_OVF_EN
  output logic                   resp_ovf,
`endif
  output logic [15:0]            op_count
);

  localparam logic [ID_W:0]   c_num  = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_last = ID_W'(NUM_REQ-1);

  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_resp_valid;
  logic [31:0]        r_resp_sum;
  logic [ID_W-1:0]    r_resp_id;
  logic [15:0]        r_op_count;

  logic               w_can_accept;
  logic [NUM_REQ-1:0] w_rot;
  logic               w_found;
  logic               w_fire;
  logic [ID_W:0]      w_off;
  logic [ID_W:0]      w_idx_sum;
  logic [ID_W:0]      w_idx_wrap;
  logic [ID_W-1:0]    w_gidx;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic [31:0]        w_sum;

  assign w_can_accept = !r_resp_valid || resp_ready;

  // Rotate so that bit 0 is the requester at rr_ptr; the lowest set bit wins.
  assign w_rot = (req_valid >> r_rr_ptr) | (req_valid << (c_num - {1'b0, r_rr_ptr}));

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (ID_W+1)'(k);
      end
    end
  end

  assign w_idx_sum  = {1'b0, r_rr_ptr} + w_off;
  assign w_idx_wrap = (w_idx_sum >= c_num) ? (w_idx_sum - c_num) : w_idx_sum;
  assign w_gidx     = w_idx_wrap[ID_W-1:0];
  assign w_fire     = w_found && w_can_accept;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign req_ready[i] = w_fire && rst_n && (w_gidx == ID_W'(i));
    end
  endgenerate

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == ID_W'(i)) begin
        w_a = req_a[32*i +: 32];
        w_b = req_b[32*i +: 32];
      end
    end
  end

  adder u_adder (
    .a   (w_a),
    .b   (w_b),
    .out (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_sum   <= '0;
      r_resp_id    <= '0;
      r_op_count   <= '0;
    end else if (w_fire) begin
      r_rr_ptr     <= (w_gidx == c_last) ? '0 : w_gidx + 1'b1;
      r_resp_valid <= 1'b1;
      r_resp_sum   <= w_sum;
      r_resp_id    <= w_gidx;
      r_op_count   <= r_op_count + 16'd1;
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic r_resp_ovf;
  logic w_ovf;

  assign w_ovf = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_ovf <= 1'b0;
    end else if (w_fire) begin
      r_resp_ovf <= w_ovf;
    end
  end

  assign resp_ovf = r_resp_ovf;
`endif

  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_resp_sum;
  assign resp_id    = r_resp_id;
  assign op_count   = r_op_count;

endmodule

`default_nettype wire
